note_roll_ctrl: RTL and testbench
=================================

// Module: note_roll_ctrl
// PURPOSE
//  Records note events into a NUM_SLOTS x NUM_NOTES piano-roll history, advancing one time
//  slot every TICK_DIV cycles, and composites that history over the graph overlay's pixel
//  stream. Sits between the note-detection logic and the VGA pixel path. The graph overlay
//  colour enters on gr_r/gr_g/gr_b, and r/g/b drive the VGA driver.
// PARAMETERS
//  NUM_SLOTS  20          time columns (x-axis length)
//  NUM_NOTES  12          pitch rows; row 0 = C (top) .. row 11 = B (bottom)
//  TICK_DIV   25_000_000  clk cycles per slot (0.5 s @ 50 MHz)
//  PLOT_X0    65          first plot-area x pixel
//  SLOT_W     27          pixels per slot; plot x = PLOT_X0 .. PLOT_X0+NUM_SLOTS*SLOT_W-1
//  ROW_Y0     30          first plot-area y pixel
//  ROW_H      35          pixels per pitch row
//  WRAP       0           0: stop when full; 1: wrap to slot 0 and overwrite
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high
//  start       in   1   pulse: begin recording (honoured in IDLE/DONE only)
//  clear       in   1   pulse: erase history, return to IDLE
//  note_valid  in   1   note_idx valid this cycle
//  note_idx    in   4   pitch class 0..11
//  x           in   10  current pixel column
//  y           in   9   current pixel row
//  gr_r/g/b    in   8   graph overlay colour for (x,y)
//  r, g, b     out  8   composited colour, 1-cycle latency from x/y/gr_*
//  busy        out  1   clear sweep in progress
//  recording   out  1   state == RECORD
//  full        out  1   state == DONE
//  slot        out  5   current write slot
// BEHAVIOUR
//  - Everything registered on clk. hist is NUM_SLOTS x NUM_NOTES bits.
//  - Reset: state=CLEAR, sweep ptr=0, slot=0, tick=0, r/g/b=0, recording=0, full=0.
//  - FSM states: CLEAR, IDLE, RECORD, DONE. clear has priority over start and note_valid.
//    CLEAR: zero hist column [ptr] each cycle, ptr++. After column NUM_SLOTS-1 -> IDLE.
//           busy=1 for exactly NUM_SLOTS cycles.
//    IDLE/DONE: start -> RECORD with slot=0, tick=0; hist is kept (cleared only by clear/reset).
//    RECORD: tick counts 0..TICK_DIV-1. When tick==TICK_DIV-1: tick=0, and
//           if slot<NUM_SLOTS-1: slot++;
//           else WRAP=0 -> DONE (slot held at NUM_SLOTS-1); WRAP=1 -> slot=0.
//           On WRAP=1, a slot is zeroed on the cycle it becomes current, so new notes
//           overwrite old ones.
//    Any state: clear -> CLEAR (ptr=0, slot=0, tick=0). start in CLEAR or RECORD is ignored.
//  - Note write: in RECORD, note_valid && note_idx<NUM_NOTES sets hist[slot][note_idx]
//    next cycle. note_idx>=NUM_NOTES is ignored. Outside RECORD, notes are ignored.
//    A write on the tick-wrap cycle lands in the old slot.
//    With WRAP=1, that write also wins over the zeroing of the old slot.
//  - Pixel path: in plot area iff PLOT_X0<=x<PLOT_X0+NUM_SLOTS*SLOT_W and
//    ROW_Y0<=y<ROW_Y0+NUM_NOTES*ROW_H.
//    col=(x-PLOT_X0)/SLOT_W and row=(y-ROW_Y0)/ROW_H; constant divide, unsigned, truncating.
//    Priority inside the plot area:
//      1. hist[col][row] set -> palette[row]
//      2. recording && col==slot -> cursor 64,64,64
//      3. otherwise -> gr_*
//    Outside the plot area -> gr_*.
//  - palette (r,g,b), rows 0..11:
//      C 90,222,0       C# 219,221,0    D 219,95,0      D# 188,0,0
//      E 233,0,88       F 233,0,226     F# 111,0,231    G 0,0,216
//      G# 0,89,233      A 0,227,233     A# 0,230,108    B 0,211,0
// TESTING (sim with TICK_DIV=4)
//  1. reset 1 cycle -> busy=1 for 20 cycles, then IDLE; gr=10,20,30 at x=5,y=5
//     -> r/g/b=10,20,30 one cycle later.
//  2. start; note_valid idx=4 in slot 0; drive x=70,y=190 -> r,g,b=233,0,88;
//     x=70,y=40 -> cursor 64,64,64.
//  3. RECORD, note_valid idx=12 -> no hist bit set; all 12 rows in col 0 return gr_*/cursor.
//  4. WRAP=0: after start, 80 cycles -> full=1, recording=0, slot=19;
//     idx=2 note then ignored (x=600,y=110 -> gr_*).
//  5. WRAP=1: note in slot 0, run 80 cycles -> slot=0, full=0, slot-0 note erased;
//     note on wrap cycle stays in slot 19.
//  6. RECORD with clear&start same cycle -> CLEAR, busy 20 cycles, history empty;
//     reset mid-RECORD -> same.

Source files
------------

// File: rtl/note_roll_ctrl.sv
// Piano-roll note history recorder with VGA pixel compositing.
// Notes are latched into a NUM_SLOTS x NUM_NOTES bit history, one time slot per
// TICK_DIV cycles, and the history is painted over the incoming graph overlay.
module note_roll_ctrl #(
    parameter int unsigned NUM_SLOTS = 20,
    parameter int unsigned NUM_NOTES = 12,
    parameter int unsigned TICK_DIV  = 25_000_000,
    parameter int unsigned PLOT_X0   = 65,
    parameter int unsigned SLOT_W    = 27,
    parameter int unsigned ROW_Y0    = 30,
    parameter int unsigned ROW_H     = 35,
    parameter int unsigned WRAP      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       clear,
    input  logic       note_valid,
    input  logic [3:0] note_idx,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic [7:0] gr_r,
    input  logic [7:0] gr_g,
    input  logic [7:0] gr_b,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       busy,
    output logic       recording,
    output logic       full,
    output logic [4:0] slot
);

    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned PLOT_X1 = PLOT_X0 + NUM_SLOTS * SLOT_W;
    localparam int unsigned ROW_Y1  = ROW_Y0 + NUM_NOTES * ROW_H;
    localparam logic [23:0] CURSOR  = {8'd64, 8'd64, 8'd64};

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_IDLE   = 2'd1,
        S_RECORD = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [4:0]                         ptr_q, ptr_d;
    logic [4:0]                         slot_q, slot_d;
    logic [TICK_W-1:0]                  tick_q, tick_d;
    logic [NUM_SLOTS-1:0][NUM_NOTES-1:0] hist_q, hist_d;
    logic                               busy_q, busy_d;
    logic                               recording_q, recording_d;
    logic                               full_q, full_d;
    logic [7:0]                         r_q, r_d;
    logic [7:0]                         g_q, g_d;
    logic [7:0]                         b_q, b_d;

    // Pixel path intermediates
    logic [9:0]  dx;
    logic [8:0]  dy;
    logic        in_area;
    logic [4:0]  col;
    logic [3:0]  row;
    logic        hit;
    logic [23:0] pal;

    // Fixed per-pitch colour table, row 0 = C.
    function automatic logic [23:0] palette(input logic [3:0] idx);
        logic [23:0] c;
        case (idx)
            4'd0:    c = {8'd90,  8'd222, 8'd0};
            4'd1:    c = {8'd219, 8'd221, 8'd0};
            4'd2:    c = {8'd219, 8'd95,  8'd0};
            4'd3:    c = {8'd188, 8'd0,   8'd0};
            4'd4:    c = {8'd233, 8'd0,   8'd88};
            4'd5:    c = {8'd233, 8'd0,   8'd226};
            4'd6:    c = {8'd111, 8'd0,   8'd231};
            4'd7:    c = {8'd0,   8'd0,   8'd216};
            4'd8:    c = {8'd0,   8'd89,  8'd233};
            4'd9:    c = {8'd0,   8'd227, 8'd233};
            4'd10:   c = {8'd0,   8'd230, 8'd108};
            4'd11:   c = {8'd0,   8'd211, 8'd0};
            default: c = 24'd0;
        endcase
        return c;
    endfunction

    // Next-state logic: sweep, slot timing and note capture into the history.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        slot_d  = slot_q;
        tick_d  = tick_q;
        hist_d  = hist_q;

        if (clear) begin
            state_d = S_CLEAR;
            ptr_d   = 5'd0;
            slot_d  = 5'd0;
            tick_d  = '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    hist_d[ptr_q] = '0;
                    if (ptr_q == 5'(NUM_SLOTS - 1)) begin
                        ptr_d   = 5'd0;
                        state_d = S_IDLE;
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_RECORD;
                        slot_d  = 5'd0;
                        tick_d  = '0;
                    end
                end
                S_RECORD: begin
                    if (tick_q == TICK_W'(TICK_DIV - 1)) begin
                        tick_d = '0;
                        if (slot_q < 5'(NUM_SLOTS - 1)) begin
                            slot_d = slot_q + 5'd1;
                            // In wrap mode each slot is wiped as it becomes current
                            if (WRAP != 0) begin
                                hist_d[slot_q + 5'd1] = '0;
                            end
                        end else if (WRAP == 0) begin
                            state_d = S_DONE;
                        end else begin
                            slot_d    = 5'd0;
                            hist_d[0] = '0;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                    // Applied after the wipe so a wrap-cycle note always survives
                    if (note_valid && (note_idx < 4'(NUM_NOTES))) begin
                        hist_d[slot_q][note_idx] = 1'b1;
                    end
                end
                default: state_d = S_CLEAR;
            endcase
        end

        busy_d      = (state_d == S_CLEAR);
        recording_d = (state_d == S_RECORD);
        full_d      = (state_d == S_DONE);
    end

    // Pixel compositing: history colour, then cursor column, then overlay.
    always_comb begin
        dx      = x - 10'(PLOT_X0);
        dy      = y - 9'(ROW_Y0);
        in_area = (x >= 10'(PLOT_X0)) && (x < 10'(PLOT_X1)) &&
                  (y >= 9'(ROW_Y0))   && (y < 9'(ROW_Y1));
        col     = 5'd0;
        row     = 4'd0;
        if (in_area) begin
            col = 5'(dx / 10'(SLOT_W));
            row = 4'(dy / 9'(ROW_H));
        end
        hit = in_area && hist_q[col][row];
        pal = palette(row);

        r_d = gr_r;
        g_d = gr_g;
        b_d = gr_b;
        if (hit) begin
            {r_d, g_d, b_d} = pal;
        end else if (in_area && recording_q && (col == slot_q)) begin
            {r_d, g_d, b_d} = CURSOR;
        end
    end

    // Control and pixel registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            ptr_q       <= 5'd0;
            slot_q      <= 5'd0;
            tick_q      <= '0;
            busy_q      <= 1'b1;
            recording_q <= 1'b0;
            full_q      <= 1'b0;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            b_q         <= 8'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            slot_q      <= slot_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
            recording_q <= recording_d;
            full_q      <= full_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    // History array; no reset needed since reset enters the clearing sweep.
    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    assign r         = r_q;
    assign g         = g_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign recording = recording_q;
    assign full      = full_q;
    assign slot      = slot_q;

endmodule

// File: tb/tb_note_roll_ctrl.sv
// Directed bench for note_roll_ctrl: one stop-when-full and one wrapping instance
// share the same stimulus, with TICK_DIV=4.
module tb_note_roll_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       note_valid = 1'b0;
    logic [3:0] note_idx = 4'd0;
    logic [9:0] x = 10'd5;
    logic [8:0] y = 9'd5;
    logic [7:0] gr_r = 8'd10;
    logic [7:0] gr_g = 8'd20;
    logic [7:0] gr_b = 8'd30;

    logic [7:0] u0_r, u0_g, u0_b, u1_r, u1_g, u1_b;
    logic       u0_busy, u0_rec, u0_full, u1_busy, u1_rec, u1_full;
    logic [4:0] u0_slot, u1_slot;

    int ncmp = 0;
    int nerr = 0;

    localparam logic [23:0] GR  = {8'd10, 8'd20, 8'd30};
    localparam logic [23:0] CUR = {8'd64, 8'd64, 8'd64};
    localparam logic [23:0] P_C  = {8'd90,  8'd222, 8'd0};
    localparam logic [23:0] P_DS = {8'd188, 8'd0,   8'd0};
    localparam logic [23:0] P_E  = {8'd233, 8'd0,   8'd88};
    localparam logic [23:0] P_F  = {8'd233, 8'd0,   8'd226};

    note_roll_ctrl #(.TICK_DIV(4), .WRAP(0)) u0 (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .note_valid(note_valid), .note_idx(note_idx), .x(x), .y(y),
        .gr_r(gr_r), .gr_g(gr_g), .gr_b(gr_b),
        .r(u0_r), .g(u0_g), .b(u0_b),
        .busy(u0_busy), .recording(u0_rec), .full(u0_full), .slot(u0_slot)
    );

    note_roll_ctrl #(.TICK_DIV(4), .WRAP(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .note_valid(note_valid), .note_idx(note_idx), .x(x), .y(y),
        .gr_r(gr_r), .gr_g(gr_g), .gr_b(gr_b),
        .r(u1_r), .g(u1_g), .b(u1_b),
        .busy(u1_busy), .recording(u1_rec), .full(u1_full), .slot(u1_slot)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a pixel, then check both instances one cycle later.
    task automatic pix(input string tag, input logic [9:0] px, input logic [8:0] py,
                       input logic [23:0] e0, input logic [23:0] e1);
        x = px;
        y = py;
        step();
        chk({tag, "_u0"}, 32'({u0_r, u0_g, u0_b}), 32'(e0));
        chk({tag, "_u1"}, 32'({u1_r, u1_g, u1_b}), 32'(e1));
    endtask

    // Count cycles with busy high in each instance, bounded.
    task automatic sweep(input string tag);
        int n0 = 0;
        int n1 = 0;
        int k  = 0;
        while ((u0_busy || u1_busy) && k < 40) begin
            if (u0_busy) n0++;
            if (u1_busy) n1++;
            k++;
            step();
        end
        chk({tag, "_busy_u0"}, 32'(n0), 32'd20);
        chk({tag, "_busy_u1"}, 32'(n1), 32'd20);
    endtask

    task automatic note(input logic [3:0] idx);
        note_valid = 1'b1;
        note_idx   = idx;
        step();
        note_valid = 1'b0;
    endtask

    initial begin
        // 1: reset, clearing sweep, pass-through
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_busy",  32'({u0_busy, u1_busy}), 32'b11);
        chk("rst_rec",   32'({u0_rec, u1_rec}),   32'b00);
        chk("rst_full",  32'({u0_full, u1_full}), 32'b00);
        chk("rst_slot",  32'({u0_slot, u1_slot}), 32'd0);
        chk("rst_rgb",   32'({u0_r, u0_g, u0_b}), 32'd0);
        sweep("t1");
        pix("t1_pass", 10'd5, 9'd5, GR, GR);

        // 2: note E in slot 0 shows palette; cursor elsewhere in column 0
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_rec", 32'({u0_rec, u1_rec}), 32'b11);
        chk("t2_slot", 32'({u0_slot, u1_slot}), 32'd0);
        note(4'd4);
        pix("t2_note", 10'd70, 9'd190, P_E, P_E);
        pix("t2_cursor", 10'd70, 9'd40, CUR, CUR);

        // 3: out-of-range pitch is dropped
        clear = 1'b1;
        step();
        clear = 1'b0;
        sweep("t3");
        start = 1'b1;
        step();
        start = 1'b0;
        note(4'd12);
        for (int i = 0; i < 12; i++) begin
            pix($sformatf("t3_row%0d", i), 10'd70, 9'(31 + 35 * i),
                (i < 3) ? CUR : GR, (i < 3) ? CUR : GR);
        end

        // 4/5: full run of 80 cycles, note on the final tick-wrap cycle
        clear = 1'b1;
        step();
        clear = 1'b0;
        sweep("t4");
        start = 1'b1;
        step();
        start = 1'b0;
        note(4'd0);
        repeat (78) step();
        note(4'd5);
        chk("t4_full",  32'({u0_full, u1_full}), 32'b10);
        chk("t4_rec",   32'({u0_rec, u1_rec}),   32'b01);
        chk("t4_slot0", 32'(u0_slot), 32'd19);
        chk("t5_slot1", 32'(u1_slot), 32'd0);
        pix("t5_slot0", 10'd70, 9'd40, P_C, CUR);
        pix("t5_wrapnote", 10'd590, 9'd210, P_F, P_F);
        note(4'd2);
        pix("t4_ignored", 10'd600, 9'd110, GR, GR);
        pix("t4_xlast", 10'd604, 9'd210, P_F, P_F);
        pix("t4_xout", 10'd605, 9'd210, GR, GR);

        // 6: clear beats start in RECORD; history is wiped
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        chk("t6_busy", 32'({u0_busy, u1_busy}), 32'b11);
        chk("t6_rec",  32'({u0_rec, u1_rec}),   32'b00);
        sweep("t6a");
        pix("t6_empty0", 10'd70, 9'd40, GR, GR);
        pix("t6_empty19", 10'd590, 9'd210, GR, GR);

        // 6: reset mid-RECORD wipes a recorded note
        start = 1'b1;
        step();
        start = 1'b0;
        note(4'd3);
        pix("t6_ds", 10'd70, 9'd140, P_DS, P_DS);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_rec", 32'({u0_rec, u1_rec}), 32'b00);
        sweep("t6b");
        pix("t6_rst_empty", 10'd70, 9'd140, GR, GR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
